tx_block_scheduler: RTL
=======================

# tx_block_scheduler

Byte-stream scheduler at the head of the TX chain on the `clk_h` domain. It shares the transport block shaper input between two requesters: the user AXIS byte stream and the PRBS validation generator. Grants are whole transport blocks, and each block is followed by a fixed inter-block gap. Modulation/bandwidth configuration for `TX_phy` is latched atomically at block boundaries only, so a block is never split across modes.

## Interface
Parameters:
- `pBLK_LEN`, 476: bytes per transport block.
- `pGAP`, 5: idle cycles inserted after each block's last byte.
- `pCNT_W`, 9: byte-counter width; must satisfy 2^pCNT_W ≥ pBLK_LEN.

Ports:
- `clk_h` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `validate_en` in 1: select PRBS source; sampled only at block start.
- `ss_in` in 4: requested config, sampled only at block start.
- `m_in` in 3: requested config, sampled only at block start.
- `bw_in` in 3: requested config, sampled only at block start.
- `data_off_in` in 1: requested config, sampled only at block start.
- `u_tdata` in 8: user byte.
- `u_tvalid` in 1: user valid.
- `u_tready` out 1: user ready.
- `p_tdata` in 8: PRBS byte.
- `p_tvalid` in 1: PRBS valid.
- `p_tready` out 1: PRBS request.
- `odata` out 8: byte to shaper.
- `oval` out 1: byte valid to shaper.
- `oreq` in 1: shaper ready.
- `osop` out 1: first byte of block, qualified by `oval`.
- `oeop` out 1: last byte of block, qualified by `oval`.
- `ss_out` out 4: latched config to `TX_phy`.
- `m_out` out 3: latched config to `TX_phy`.
- `bw_out` out 3: latched config to `TX_phy`.
- `data_off_out` out 1: latched config to `TX_phy`.
- `cfg_upd` out 1: one-cycle pulse when the latched config changes.
- `src_prbs` out 1: the current or last block came from PRBS.
- `blk_cnt` out 16: completed blocks, wraps modulo 2^16.

## Operation
- FSM states: `IDLE`, `GRANT`, `GAP`.
- `IDLE`: decides the source for the next block.
  - `validate_en=1` → PRBS.
  - Otherwise `u_tvalid=1` → user.
  - Otherwise stay in `IDLE` (see Configuration for the alternative).
  - On leaving `IDLE`, latch `src_prbs` and all `*_in` config into `*_out`. Pulse `cfg_upd` in the next cycle if any latched field differs from its previous value.
- `GRANT`: combinational pass-through from the selected source.
  - `odata` = selected tdata; `oval` = selected tvalid.
  - Selected tready = `oreq`; the non-selected tready = 0.
  - A transfer is `oval & oreq`.
  - Byte counter `cnt` resets to 0 on entry and increments per transfer.
  - `osop` = (`cnt`==0); `oeop` = (`cnt`==pBLK_LEN-1).
  - A transfer with `oeop` → `GAP`, `blk_cnt`+1.
- A source stall (valid low) mid-block holds `GRANT` indefinitely, with no timeout and no source switch.
- Changes to `validate_en` and config inputs during `GRANT`/`GAP` are ignored until the next `IDLE` decision.
- `GAP`: `oval`=0 and both treadies 0 for exactly pGAP cycles, then → `IDLE`.
- Reset values: state `IDLE`; all outputs 0; `cnt`=0; `*_out`=0; `blk_cnt`=0.
- Reset asserted mid-block discards the partial block. No `oeop` is produced, and upstream sources must tolerate the abandoned bytes.

## Timing
- `IDLE` decision takes 1 cycle; the first byte can transfer in the first `GRANT` cycle.
- Data path latency is 0 cycles (combinational).
- Back-to-back blocks with continuous valid/ready have a period of 1 + pBLK_LEN + pGAP = 482 cycles at defaults.
- `*_out` update on the clock edge leaving `IDLE`, one cycle before the block's first byte can transfer. `cfg_upd` is coincident with the first `GRANT` cycle.
- `blk_cnt` updates on the edge after the `oeop` transfer. It wraps 0xFFFF → 0x0000.
- The `oeop` transfer and the `GAP` entry happen on the same edge, so there is no extra byte.

## Configuration
- Macro `TX_SCHED_FILL_EN`.
  - Defined: in `IDLE`, with `validate_en=0` and `u_tvalid=0`, the FSM grants a PRBS filler block. `src_prbs`=1 so the link keeps transmitting.
  - Undefined: the FSM waits in `IDLE` with `oval`=0 until user data or `validate_en` arrives.

## Test plan
- Reset, then `u_tvalid`=1 and `oreq`=1 continuously → `osop` on byte 0, `oeop` on byte 475, then 5 cycles of `oval`=0; `blk_cnt`=1 after the first block, and the next `osop` arrives 482 cycles after the previous one.
- `validate_en` toggled 0→1 mid user block → the current block completes from user (476 bytes), and the next block has `src_prbs`=1 with `u_tready`=0 throughout.
- Change `m_in` 2→4 mid block → `m_out` stays 2 until the next `IDLE` exit, then becomes 4 with a single `cfg_upd` pulse; an unchanged config produces no pulse.
- `oreq` low for 10 cycles and `u_tvalid` low for 7 cycles mid block → byte count stays exactly 476, with no duplicated or dropped bytes versus a reference queue.
- `rst` asserted at byte 200 → all outputs 0 immediately; after release, the next block starts at `cnt`=0 with `osop`, and `blk_cnt`=0.
- With all sources idle: with `TX_SCHED_FILL_EN` a PRBS block starts within 1 cycle of `GAP` end; without the macro, `oval` stays 0 for 1000 cycles.

Source files
------------

// File: rtl/tx_block_scheduler.sv
// Whole-block arbiter between the user AXIS stream and the PRBS generator, with a fixed
// inter-block gap and config latched at block start. Optional TX_SCHED_FILL_EN grants PRBS filler when idle.
module tx_block_scheduler #(
  parameter int unsigned pBLK_LEN = 476,
  parameter int unsigned pGAP     = 5,
  parameter int unsigned pCNT_W   = 9
) (
  input  logic        clk_h,
  input  logic        rst,
  input  logic        validate_en,
  input  logic [3:0]  ss_in,
  input  logic [2:0]  m_in,
  input  logic [2:0]  bw_in,
  input  logic        data_off_in,
  input  logic [7:0]  u_tdata,
  input  logic        u_tvalid,
  output logic        u_tready,
  input  logic [7:0]  p_tdata,
  input  logic        p_tvalid,
  output logic        p_tready,
  output logic [7:0]  odata,
  output logic        oval,
  input  logic        oreq,
  output logic        osop,
  output logic        oeop,
  output logic [3:0]  ss_out,
  output logic [2:0]  m_out,
  output logic [2:0]  bw_out,
  output logic        data_off_out,
  output logic        cfg_upd,
  output logic        src_prbs,
  output logic [15:0] blk_cnt
);
  localparam int unsigned GAP_W = (pGAP > 1) ? $clog2(pGAP) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

  state_e            state_q, state_d;
  logic [pCNT_W-1:0] cnt_q;
  logic [GAP_W-1:0]  gap_q;
  logic              src_q;
  logic [10:0]       cfg_q;
  logic              cfg_upd_q;
  logic [15:0]       blk_q;

  logic        start, sel_prbs, last, gap_done, xfer, sel_vld;
  logic [10:0] cfg_in;

  assign cfg_in = {ss_in, m_in, bw_in, data_off_in};

`ifdef TX_SCHED_FILL_EN
  // Keep the link busy: with nothing else pending, PRBS fills the block.
  assign start    = 1'b1;
  assign sel_prbs = validate_en | ~u_tvalid;
`else
  assign start    = validate_en | u_tvalid;
  assign sel_prbs = validate_en;
`endif

  assign last     = (cnt_q == pCNT_W'(pBLK_LEN - 1));
  assign gap_done = (gap_q == GAP_W'(pGAP - 1));
  assign sel_vld  = src_q ? p_tvalid : u_tvalid;
  assign xfer     = oval & oreq;

  always_ff @(posedge clk_h or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)        state_d = GRANT;
      GRANT:   if (xfer && last) state_d = GAP;
      GAP:     if (gap_done)     state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    odata    = 8'h00;
    oval     = 1'b0;
    u_tready = 1'b0;
    p_tready = 1'b0;
    osop     = 1'b0;
    oeop     = 1'b0;
    if (state_q == GRANT) begin
      odata    = src_q ? p_tdata : u_tdata;
      oval     = sel_vld;
      u_tready = ~src_q & oreq;
      p_tready = src_q & oreq;
      osop     = sel_vld & (cnt_q == '0);
      oeop     = sel_vld & last;
    end
  end

  always_ff @(posedge clk_h or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      gap_q     <= '0;
      src_q     <= 1'b0;
      cfg_q     <= '0;
      cfg_upd_q <= 1'b0;
      blk_q     <= '0;
    end else begin
      cfg_upd_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          cnt_q     <= '0;
          src_q     <= sel_prbs;
          cfg_q     <= cfg_in;
          cfg_upd_q <= (cfg_in != cfg_q);
        end
        GRANT: if (xfer) begin
          if (last) begin
            blk_q <= blk_q + 16'd1;
            gap_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP: gap_q <= gap_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign {ss_out, m_out, bw_out, data_off_out} = cfg_q;
  assign cfg_upd  = cfg_upd_q;
  assign src_prbs = src_q;
  assign blk_cnt  = blk_q;
endmodule
